// File: rtl/mult_booth_seq.sv
// Sequential radix-2 Booth signed multiplier built around a single 32-bit carry-lookahead adder.
// Optional macro MULT_HI_OUT_EN adds the registered upper product word data_result_hi.

module cla #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             c0,
  output logic [WIDTH-1:0] s,
  output logic             ovf
);

  localparam int NB = WIDTH / 4;

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;
  logic [NB-1:0]    bg;
  logic [NB-1:0]    bp;
  logic [NB:0]      bc;

  // 4-bit lookahead groups; group carries chain between blocks.
  always_comb begin
    g  = x & y;
    p  = x ^ y;
    c  = '0;
    bg = '0;
    bp = '0;
    bc = '0;
    bc[0] = c0;
    for (int b = 0; b < NB; b++) begin
      bp[b] = &p[4*b +: 4];
      bg[b] = g[4*b+3]
            | (p[4*b+3] & g[4*b+2])
            | (p[4*b+3] & p[4*b+2] & g[4*b+1])
            | (p[4*b+3] & p[4*b+2] & p[4*b+1] & g[4*b]);
      bc[b+1] = bg[b] | (bp[b] & bc[b]);
    end
    for (int b = 0; b < NB; b++) begin
      c[4*b]   = bc[b];
      c[4*b+1] = g[4*b] | (p[4*b] & bc[b]);
      c[4*b+2] = g[4*b+1]
               | (p[4*b+1] & g[4*b])
               | (p[4*b+1] & p[4*b] & bc[b]);
      c[4*b+3] = g[4*b+2]
               | (p[4*b+2] & g[4*b+1])
               | (p[4*b+2] & p[4*b+1] & g[4*b])
               | (p[4*b+2] & p[4*b+1] & p[4*b] & bc[b]);
    end
    c[WIDTH] = bc[NB];
    s   = p ^ c[WIDTH-1:0];
    ovf = c[WIDTH] ^ c[WIDTH-1];
  end

endmodule

module mult_booth_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
`ifdef MULT_HI_OUT_EN
  output logic [WIDTH-1:0] data_result_hi,
  output logic             data_resultRDY
`else
  output logic             data_resultRDY
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]              state;
  logic [CNT_W-1:0]        cnt;
  logic signed [WIDTH-1:0] m;
  logic signed [WIDTH-1:0] a;
  logic signed [WIDTH-1:0] q;
  logic                    qm1;

  logic                    do_add;
  logic [WIDTH-1:0]        cla_y;
  logic                    cla_c0;
  logic [WIDTH-1:0]        cla_s;
  logic                    cla_ovf;

  logic [WIDTH-1:0]          s;
  logic                      sgn;
  logic signed [WIDTH-1:0]   a_nxt;
  logic signed [WIDTH-1:0]   q_nxt;
  logic signed [2*WIDTH-1:0] prod;

  // True when the upper WIDTH+1 product bits are a pure sign extension.
  function automatic logic fits_signed(input logic [WIDTH:0] top);
    return (&top) | (~|top);
  endfunction

  always_comb begin
    do_add = 1'b0;
    cla_y  = m;
    cla_c0 = 1'b0;
    case ({q[0], qm1})
      2'b01: begin
        do_add = 1'b1;
        cla_y  = m;
        cla_c0 = 1'b0;
      end
      2'b10: begin
        do_add = 1'b1;
        cla_y  = ~m;
        cla_c0 = 1'b1;
      end
      default: ;
    endcase
  end

  cla #(.WIDTH(WIDTH)) u_cla (
    .x   (a),
    .y   (cla_y),
    .c0  (cla_c0),
    .s   (cla_s),
    .ovf (cla_ovf)
  );

  // Overflow-corrected sign bit keeps the shift exact for M = most negative value.
  always_comb begin
    s     = do_add ? cla_s : a;
    sgn   = do_add ? (cla_s[WIDTH-1] ^ cla_ovf) : a[WIDTH-1];
    a_nxt = {sgn, s[WIDTH-1:1]};
    q_nxt = {s[0], q[WIDTH-1:1]};
    prod  = {a_nxt, q_nxt};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      m              <= '0;
      a              <= '0;
      q              <= '0;
      qm1            <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
`ifdef MULT_HI_OUT_EN
      data_result_hi <= '0;
`endif
    end else begin
      data_resultRDY <= 1'b0;
      if (ctrl_MULT) begin
        m     <= data_operandA;
        q     <= data_operandB;
        a     <= '0;
        qm1   <= 1'b0;
        cnt   <= '0;
        state <= RUN;
      end else begin
        case (state)
          RUN: begin
            a   <= a_nxt;
            q   <= q_nxt;
            qm1 <= q[0];
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(WIDTH-1)) begin
              data_result    <= prod[WIDTH-1:0];
              data_exception <= ~fits_signed(prod[2*WIDTH-1:WIDTH-1]);
              data_resultRDY <= 1'b1;
`ifdef MULT_HI_OUT_EN
              data_result_hi <= prod[2*WIDTH-1:WIDTH];
`endif
              state          <= DONE;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mult_booth_seq.sv
// Self-checking bench for mult_booth_seq: directed and random products checked against
// a plain 64-bit arithmetic model, plus restart, back-to-back and mid-run reset scenarios.

module tb_mult_booth_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
`ifdef MULT_HI_OUT_EN
  logic [31:0] data_result_hi;
`endif

  int total = 0;
  int bad   = 0;

  mult_booth_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .data_result    (data_result),
    .data_exception (data_exception),
`ifdef MULT_HI_OUT_EN
    .data_result_hi (data_result_hi),
`endif
    .data_resultRDY (data_resultRDY)
  );

  always #5 clock = ~clock;

  function automatic longint ref_prod(input logic [31:0] x, input logic [31:0] y);
    return longint'($signed(x)) * longint'($signed(y));
  endfunction

  function automatic logic ref_exc(input longint p);
    logic [31:0] lo;
    lo = p[31:0];
    return p != longint'($signed(lo));
  endfunction

  // Drives a one-cycle start strobe; operands are scrambled afterwards.
  task automatic start(input logic [31:0] x, input logic [31:0] y);
    @(negedge clock);
    data_operandA = x;
    data_operandB = y;
    ctrl_MULT     = 1'b1;
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // Counts falling edges until RDY is seen, bounded at 40.
  task automatic wait_rdy(output int n);
    n = 0;
    while (n < 40) begin
      @(negedge clock);
      n++;
      if (data_resultRDY) break;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    ctrl_MULT = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    #12;
    total++;
    if (data_result !== 32'h0 || data_exception !== 1'b0 || data_resultRDY !== 1'b0) begin
      $display("FAIL reset_outputs: got res=%h exc=%b rdy=%b want 0/0/0",
               data_result, data_exception, data_resultRDY);
      bad++;
    end
`ifdef MULT_HI_OUT_EN
    total++;
    if (data_result_hi !== 32'h0) begin
      $display("FAIL reset_hi: got %h want 0", data_result_hi);
      bad++;
    end
`endif
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_products;
    logic [31:0] xa [$];
    logic [31:0] xb [$];
    longint p;
    int n;
    xa = '{32'd3, 32'hFFFFFFF9, 32'h00010000, 32'h80000000};
    xb = '{32'd5, 32'd6,        32'h00010000, 32'hFFFFFFFF};
    for (int i = 0; i < 4; i++) begin
      xa.push_back($urandom);
      xb.push_back($urandom);
    end
    for (int i = 0; i < 4; i++) begin
      xa.push_back(32'($signed(16'($urandom))));
      xb.push_back(32'($signed(15'($urandom))));
    end
    for (int i = 0; i < xa.size(); i++) begin
      p = ref_prod(xa[i], xb[i]);
      start(xa[i], xb[i]);
      wait_rdy(n);
      total++;
      if (n !== 32) begin
        $display("FAIL prod_latency[%0d]: got %0d edges want 32", i, n);
        bad++;
      end
      total++;
      if (data_result !== p[31:0]) begin
        $display("FAIL prod_result[%0d] %h*%h: got %h want %h", i, xa[i], xb[i], data_result, p[31:0]);
        bad++;
      end
      total++;
      if (data_exception !== ref_exc(p)) begin
        $display("FAIL prod_exc[%0d] %h*%h: got %b want %b", i, xa[i], xb[i], data_exception, ref_exc(p));
        bad++;
      end
`ifdef MULT_HI_OUT_EN
      total++;
      if (data_result_hi !== p[63:32]) begin
        $display("FAIL prod_hi[%0d]: got %h want %h", i, data_result_hi, p[63:32]);
        bad++;
      end
`endif
      repeat (2) @(negedge clock);
      total++;
      if (data_resultRDY !== 1'b0 || data_result !== p[31:0]) begin
        $display("FAIL prod_hold[%0d]: got rdy=%b res=%h want 0/%h", i, data_resultRDY, data_result, p[31:0]);
        bad++;
      end
    end
  endtask

  task automatic test_restart;
    int n;
    int early;
    early = 0;
    start(32'd100, 32'd3);
    repeat (9) begin
      @(negedge clock);
      if (data_resultRDY) early++;
    end
    start(32'd2, 32'd2);
    wait_rdy(n);
    total++;
    if (n !== 32 || early !== 0) begin
      $display("FAIL restart_timing: got %0d edges early=%0d want 32/0", n, early);
      bad++;
    end
    total++;
    if (data_result !== 32'd4 || data_exception !== 1'b0) begin
      $display("FAIL restart_result: got %h/%b want 00000004/0", data_result, data_exception);
      bad++;
    end
    early = 0;
    repeat (30) begin
      @(negedge clock);
      if (data_resultRDY) early++;
    end
    total++;
    if (early !== 0) begin
      $display("FAIL restart_single_rdy: got %0d extra pulses want 0", early);
      bad++;
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] x1, y1, x2, y2;
    longint p1, p2;
    int n1, n2;
    x1 = $urandom; y1 = $urandom_range(1000, 1);
    x2 = $urandom_range(50000, 1); y2 = $urandom;
    p1 = ref_prod(x1, y1);
    p2 = ref_prod(x2, y2);
    start(x1, y1);
    wait_rdy(n1);
    total++;
    if (n1 !== 32 || data_result !== p1[31:0] || data_exception !== ref_exc(p1)) begin
      $display("FAIL b2b_first: got n=%0d res=%h exc=%b want 32/%h/%b", n1, data_result, data_exception, p1[31:0], ref_exc(p1));
      bad++;
    end
    data_operandA = x2;
    data_operandB = y2;
    ctrl_MULT     = 1'b1;
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    wait_rdy(n2);
    total++;
    if (n2 !== 32 || data_result !== p2[31:0] || data_exception !== ref_exc(p2)) begin
      $display("FAIL b2b_second: got n=%0d res=%h exc=%b want 32/%h/%b", n2, data_result, data_exception, p2[31:0], ref_exc(p2));
      bad++;
    end
  endtask

  task automatic test_reset_midrun;
    int n;
    int seen;
    seen = 0;
    start(32'd7, 32'd9);
    repeat (14) @(negedge clock);
    reset = 1'b1;
    #1;
    total++;
    if (data_result !== 32'h0 || data_exception !== 1'b0 || data_resultRDY !== 1'b0) begin
      $display("FAIL midrun_reset_outputs: got res=%h exc=%b rdy=%b want 0/0/0", data_result, data_exception, data_resultRDY);
      bad++;
    end
    @(negedge clock);
    reset = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY) seen++;
    end
    total++;
    if (seen !== 0) begin
      $display("FAIL midrun_no_rdy: got %0d pulses want 0", seen);
      bad++;
    end
    start(32'd1, 32'd1);
    wait_rdy(n);
    total++;
    if (n !== 32 || data_result !== 32'd1 || data_exception !== 1'b0) begin
      $display("FAIL midrun_recover: got n=%0d res=%h exc=%b want 32/00000001/0", n, data_result, data_exception);
      bad++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_products();
    test_restart();
    test_back_to_back();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
